card_datapath: RTL and testbench

//  Responder side of the baccarat dealing interface. It consumes the six

---
 rtl/card_datapath.sv | 133 +++++++++++++
 tb/tb_card_datapath.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/card_datapath.sv
// Baccarat dealing datapath: a free-running 1..13 rank counter feeds six card slots,
// and per-hand score logic returns pscore, dscore and pcard3 to the hand-control FSM.

module card_hand #(
    parameter int NUM_SLOTS = 3
) (
    input  logic                       slow_clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [NUM_SLOTS-1:0]       load,
    input  logic [3:0]                 rank,
    output logic [NUM_SLOTS-1:0][3:0]  ranks,
    output logic [NUM_SLOTS-1:0][3:0]  values,
    output logic [3:0]                 score
);

    function automatic logic [3:0] card_value(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
    endfunction

    logic [4:0] sum;

    genvar s;
    generate
        for (s = 0; s < NUM_SLOTS; s++) begin : g_slot
            // clear beats load so a new hand never starts with a stale card
            always_ff @(posedge slow_clock or posedge reset) begin
                if (reset)
                    ranks[s] <= 4'd0;
                else if (clear)
                    ranks[s] <= 4'd0;
                else if (load[s])
                    ranks[s] <= rank;
            end

            assign values[s] = card_value(ranks[s]);
        end
    endgenerate

    always_comb begin
        sum = 5'd0;
        for (int i = 0; i < NUM_SLOTS; i++)
            sum = sum + 5'(values[i]);
    end

    // sum is at most 27, so two conditional subtractions give mod 10
    always_comb begin
        score = 4'd0;
        if (sum >= 5'd20)
            score = 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            score = 4'(sum - 5'd10);
        else
            score = sum[3:0];
    end

endmodule

module card_datapath #(
    parameter logic [3:0] SEED = 4'd1
) (
    input  logic        slow_clock,
    input  logic        reset,
    input  logic        new_hand,
    input  logic        load_pcard1,
    input  logic        load_pcard2,
    input  logic        load_pcard3,
    input  logic        load_dcard1,
    input  logic        load_dcard2,
    input  logic        load_dcard3,
    output logic [11:0] p_ranks,
    output logic [11:0] d_ranks,
    output logic [3:0]  pscore,
    output logic [3:0]  dscore,
    output logic [3:0]  pcard3,
    output logic        err_multi_load
);

    localparam int NUM_HANDS = 2;
    localparam int NUM_SLOTS = 3;

    logic [3:0]                                 deal_rank;
    logic [NUM_HANDS-1:0][NUM_SLOTS-1:0]        hand_load;
    logic [NUM_HANDS-1:0][NUM_SLOTS-1:0][3:0]   hand_ranks;
    logic [NUM_HANDS-1:0][NUM_SLOTS-1:0][3:0]   hand_values;
    logic [NUM_HANDS-1:0][3:0]                  hand_score;

    // hand 0 is the player, hand 1 the dealer; slot index 0 is card 1
    assign hand_load[0] = {load_pcard3, load_pcard2, load_pcard1};
    assign hand_load[1] = {load_dcard3, load_dcard2, load_dcard1};

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset)
            deal_rank <= SEED;
        else if (deal_rank == 4'd13)
            deal_rank <= 4'd1;
        else
            deal_rank <= deal_rank + 4'd1;
    end

    genvar h;
    generate
        for (h = 0; h < NUM_HANDS; h++) begin : g_hand
            card_hand #(
                .NUM_SLOTS (NUM_SLOTS)
            ) u_hand (
                .slow_clock (slow_clock),
                .reset      (reset),
                .clear      (new_hand),
                .load       (hand_load[h]),
                .rank       (deal_rank),
                .ranks      (hand_ranks[h]),
                .values     (hand_values[h]),
                .score      (hand_score[h])
            );
        end
    endgenerate

    // strobes masked by new_hand are ignored, so they cannot raise the error
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset)
            err_multi_load <= 1'b0;
        else if (!new_hand && $countones(hand_load) > 1)
            err_multi_load <= 1'b1;
    end

    assign p_ranks = hand_ranks[0];
    assign d_ranks = hand_ranks[1];
    assign pscore  = hand_score[0];
    assign dscore  = hand_score[1];
    assign pcard3  = hand_values[0][2];

endmodule

// File: tb/tb_card_datapath.sv
// Directed bench for card_datapath: stimulus pushes expected hand state into a
// queue tagged with the cycle it must appear in; a monitor pops and compares.

module tb_card_datapath;

    logic        slow_clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_hand = 1'b0;
    logic        load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
    logic        load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
    logic [11:0] p_ranks, d_ranks;
    logic [3:0]  pscore, dscore, pcard3;
    logic        err_multi_load;

    card_datapath #(.SEED(4'd1)) dut (
        .slow_clock     (slow_clock),
        .reset          (reset),
        .new_hand       (new_hand),
        .load_pcard1    (load_pcard1),
        .load_pcard2    (load_pcard2),
        .load_pcard3    (load_pcard3),
        .load_dcard1    (load_dcard1),
        .load_dcard2    (load_dcard2),
        .load_dcard3    (load_dcard3),
        .p_ranks        (p_ranks),
        .d_ranks        (d_ranks),
        .pscore         (pscore),
        .dscore         (dscore),
        .pcard3         (pcard3),
        .err_multi_load (err_multi_load)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        int          cyc;
        logic [11:0] p;
        logic [11:0] d;
        logic [3:0]  ps;
        logic [3:0]  ds;
        logic [3:0]  pc3;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    miscompares = 0;
    event  mid_chk;

    always @(posedge slow_clock) cyc <= cyc + 1;

    task automatic push(input string name, input logic [11:0] p, input logic [11:0] d,
                        input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                        input logic err, input int tgt);
        exp_t e;
        e.cyc = tgt; e.p = p; e.d = d; e.ps = ps; e.ds = ds; e.pc3 = pc3; e.err = err;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // strobes packed as {p1,p2,p3,d1,d2,d3}
    task automatic ld(input logic [5:0] v);
        {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} = v;
    endtask

    task automatic step();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge slow_clock or mid_chk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                vectors++;
                if (e.cyc < cyc) begin
                    miscompares++;
                    $display("FAIL %s: check missed, due cycle %0d, now %0d", n, e.cyc, cyc);
                end else if (p_ranks !== e.p || d_ranks !== e.d || pscore !== e.ps ||
                             dscore !== e.ds || pcard3 !== e.pc3 || err_multi_load !== e.err) begin
                    miscompares++;
                    $display("FAIL %s: got p=%h d=%h ps=%0d ds=%0d pc3=%0d err=%b, want p=%h d=%h ps=%0d ds=%0d pc3=%0d err=%b",
                             n, p_ranks, d_ranks, pscore, dscore, pcard3, err_multi_load,
                             e.p, e.d, e.ps, e.ds, e.pc3, e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus; comments give the deal rank sampled at each edge after reset release
    initial begin
        ld(6'b0);
        step(); step();
        push("reset_state", 12'h000, 12'h000, 0, 0, 0, 1'b0, cyc + 1);
        step();

        reset = 1'b0;
        ld(6'b100000);                                              // E1: rank 1
        push("seed_pcard1", 12'h001, 12'h000, 1, 0, 0, 1'b0, cyc + 1);
        step();
        ld(6'b0);
        repeat (11) step();                                         // E2..E12
        ld(6'b000100);                                              // E13: rank 13
        push("dcard1_rank13", 12'h001, 12'h00D, 1, 0, 0, 1'b0, cyc + 1);
        step();
        push("dcard1_wrap", 12'h001, 12'h001, 1, 1, 0, 1'b0, cyc + 1); // E14: rank 1, held strobe
        step();

        ld(6'b0);
        new_hand = 1'b1;                                            // E15
        push("new_hand_clear", 12'h000, 12'h000, 0, 0, 0, 1'b0, cyc + 1);
        step();
        new_hand = 1'b0;
        repeat (4) step();                                          // E16..E19
        ld(6'b001000);                                              // E20: rank 7
        push("pcard3_7", 12'h700, 12'h000, 7, 0, 7, 1'b0, cyc + 1);
        step();
        ld(6'b010000);                                              // E21: rank 8
        push("pcard2_8", 12'h780, 12'h000, 5, 0, 7, 1'b0, cyc + 1);
        step();
        ld(6'b100000);                                              // E22: rank 9
        push("pscore_24", 12'h789, 12'h000, 4, 0, 7, 1'b0, cyc + 1);
        step();
        ld(6'b000100);                                              // E23: rank 10
        push("dcard1_10", 12'h789, 12'h00A, 4, 0, 7, 1'b0, cyc + 1);
        step();
        ld(6'b0);
        step();                                                     // E24
        ld(6'b000010);                                              // E25: rank 12
        push("dcard2_12", 12'h789, 12'h0CA, 4, 0, 7, 1'b0, cyc + 1);
        step();
        ld(6'b0);
        repeat (5) step();                                          // E26..E30
        ld(6'b000001);                                              // E31: rank 5
        push("dscore_5", 12'h789, 12'h5CA, 4, 5, 7, 1'b0, cyc + 1);
        step();

        ld(6'b010010);                                              // E32: rank 6, two strobes
        push("multi_load", 12'h769, 12'h56A, 2, 1, 7, 1'b1, cyc + 1);
        step();
        ld(6'b100000);
        new_hand = 1'b1;                                            // E33: new_hand wins
        push("new_hand_priority", 12'h000, 12'h000, 0, 0, 0, 1'b1, cyc + 1);
        step();
        new_hand = 1'b0;                                            // E34: rank 8, counter kept running
        push("counter_unaffected", 12'h008, 12'h000, 8, 0, 0, 1'b1, cyc + 1);
        step();
        ld(6'b000001);                                              // E35: rank 9
        push("dcard3_9", 12'h008, 12'h900, 8, 9, 0, 1'b1, cyc + 1);
        step();

        ld(6'b0);
        #2;
        reset = 1'b1;
        push("async_reset", 12'h000, 12'h000, 0, 0, 0, 1'b0, cyc);
        -> mid_chk;
        @(negedge slow_clock);
        reset = 1'b0;
        ld(6'b100000);
        push("post_reset_seed", 12'h001, 12'h000, 1, 0, 0, 1'b0, cyc + 1);
        step();
        ld(6'b0);
        repeat (3) step();

        if (exp_q.size() != 0) begin
            miscompares += exp_q.size();
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
